uc_seq: RTL

UC_SEQ -- requirements
Module: uc_seq

---
 rtl/uc_seq.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uc_seq.sv
// ---------------------------------------------------------------------------
// uc_seq -- tiny microcoded sequencer
//
// Fetches 16-bit instructions from an external synchronous-read program
// memory (one cycle of read latency) and executes one per cycle once the
// fetch pipeline is primed.  Supports output writes, conditional jumps,
// call/return through a small hardware stack, and a counted loop.
//
// Ports
//   clk      : single clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : begin execution at START_ADDR (only acted on when idle)
//   abort    : synchronous stop, returns to idle, wins over everything
//   pc       : fetch address presented to the program memory
//   opcode   : memory data for the pc presented on the previous edge
//   cond_in  : branch condition bits selected by JMP
//   out      : registered output word written by OUT
//   out_stb  : one-cycle pulse after out is written
//   busy     : high while priming the pipeline or executing
//   done     : one-cycle pulse after HALT executes
//   err      : sticky stack fault flag, cleared by start or reset
// ---------------------------------------------------------------------------
module uc_seq #(
    parameter int AW         = 8,
    parameter int CW         = 4,
    parameter int OUTW       = 4,
    parameter int SD         = 4,
    parameter int START_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [AW-1:0]   pc,
    input  logic [15:0]     opcode,
    input  logic [CW-1:0]   cond_in,
    output logic [OUTW-1:0] out,
    output logic            out_stb,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [3:0] OP_OUT  = 4'd1;
    localparam logic [3:0] OP_JMP  = 4'd2;
    localparam logic [3:0] OP_CALL = 4'd3;
    localparam logic [3:0] OP_RET  = 4'd4;
    localparam logic [3:0] OP_LDC  = 4'd5;
    localparam logic [3:0] OP_DJNZ = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

    // Stack pointer counts entries, so it must be able to hold SD itself.
    localparam int            SPW      = $clog2(SD + 1);
    localparam logic [AW-1:0] START_PC = AW'(START_ADDR);
    localparam logic [AW-1:0] PC_ONE   = AW'(1);
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(SD);

    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   epc_q, epc_d;
    logic [OUTW-1:0] out_q, out_d;
    logic            out_stb_q, out_stb_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [SPW-1:0]  sp_q, sp_d;
    logic [AW-1:0]   stack_q [SD];
    logic [AW-1:0]   stack_d [SD];

    logic [3:0]      op_class;
    logic [AW-1:0]   target;
    logic [2:0]      cond_idx;
    logic            cond_bit;
    logic            jmp_taken;
    logic [AW-1:0]   ret_addr;
    logic [AW-1:0]   pc_inc;

    assign pc      = pc_q;
    assign out     = out_q;
    assign out_stb = out_stb_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = (state_q == ST_FILL) || (state_q == ST_RUN);

    // Instruction field decode plus the condition mux and the stack top.
    // A condition index beyond the implemented inputs reads as zero, which
    // the loop gives for free since no iteration matches it.
    always_comb begin
        op_class = opcode[15:12];
        target   = opcode[AW-1:0];
        cond_idx = opcode[10:8];
        pc_inc   = pc_q + PC_ONE;
        cond_bit = 1'b0;
        for (int i = 0; i < CW; i++) begin
            if (cond_idx == 3'(i)) begin
                cond_bit = cond_in[i];
            end
        end
        jmp_taken = cond_bit ^ opcode[11];
        ret_addr  = '0;
        for (int i = 0; i < SD; i++) begin
            if (SPW'(i) == (sp_q - SP_ONE)) begin
                ret_addr = stack_q[i];
            end
        end
    end

    // Next-state logic.  pc runs one address ahead of epc, the address of
    // the instruction currently on opcode.  Any taken control transfer
    // reloads pc and drops back to FILL to absorb the memory latency.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        out_d     = out_q;
        out_stb_d = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;
        cnt_d     = cnt_q;
        sp_d      = sp_q;
        stack_d   = stack_q;

        if (abort) begin
            state_d = ST_IDLE;
            pc_d    = START_PC;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_FILL;
                        pc_d    = START_PC;
                        err_d   = 1'b0;
                        sp_d    = '0;
                    end
                end
                ST_FILL: begin
                    state_d = ST_RUN;
                    pc_d    = pc_inc;
                    epc_d   = pc_q;
                end
                ST_RUN: begin
                    pc_d  = pc_inc;
                    epc_d = pc_q;
                    case (op_class)
                        OP_OUT: begin
                            out_d     = opcode[OUTW-1:0];
                            out_stb_d = 1'b1;
                        end
                        OP_JMP: begin
                            if (jmp_taken) begin
                                pc_d    = target;
                                state_d = ST_FILL;
                            end
                        end
                        OP_CALL: begin
                            if (sp_q == SP_FULL) begin
                                err_d   = 1'b1;
                                state_d = ST_IDLE;
                                pc_d    = START_PC;
                            end else begin
                                for (int i = 0; i < SD; i++) begin
                                    if (SPW'(i) == sp_q) begin
                                        stack_d[i] = epc_q + PC_ONE;
                                    end
                                end
                                sp_d    = sp_q + SP_ONE;
                                pc_d    = target;
                                state_d = ST_FILL;
                            end
                        end
                        OP_RET: begin
                            if (sp_q == '0) begin
                                err_d   = 1'b1;
                                state_d = ST_IDLE;
                                pc_d    = START_PC;
                            end else begin
                                sp_d    = sp_q - SP_ONE;
                                pc_d    = ret_addr;
                                state_d = ST_FILL;
                            end
                        end
                        OP_LDC: begin
                            cnt_d = opcode[7:0];
                        end
                        OP_DJNZ: begin
                            if (cnt_q != 8'd0) begin
                                cnt_d   = cnt_q - 8'd1;
                                pc_d    = target;
                                state_d = ST_FILL;
                            end
                        end
                        OP_HALT: begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                            pc_d    = START_PC;
                        end
                        default: begin
                        end
                    endcase
                end
                default: begin
                    state_d = ST_IDLE;
                    pc_d    = START_PC;
                end
            endcase
        end
    end

    // State registers; everything returns to idle values the moment rst_n
    // falls, without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= START_PC;
            epc_q     <= START_PC;
            out_q     <= '0;
            out_stb_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= 8'd0;
            sp_q      <= '0;
            for (int i = 0; i < SD; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            out_q     <= out_d;
            out_stb_q <= out_stb_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            sp_q      <= sp_d;
            for (int i = 0; i < SD; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

endmodule
